// File: rtl/mem_access_pkg.sv
// Shared FSM state type, access-type encodings and size/legality helpers
// for the multi-cycle load/store unit.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_RESP
  } state_t;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_D  = 3'b011;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;
  localparam logic [2:0] RW_WU = 3'b110;

  // Access size in bytes; unsigned variants share the size of their signed twin.
  function automatic logic [3:0] size_of(input logic [2:0] rw_type);
    logic [3:0] sz;
    case (rw_type)
      RW_B, RW_BU: sz = 4'd1;
      RW_H, RW_HU: sz = 4'd2;
      RW_W, RW_WU: sz = 4'd4;
      default:     sz = 4'd8;
    endcase
    return sz;
  endfunction

  function automatic logic type_legal(input logic [2:0] rw_type, input int unsigned xlen);
    logic ok;
    case (rw_type)
      RW_B, RW_H, RW_W, RW_BU, RW_HU: ok = 1'b1;
      RW_D, RW_WU:                    ok = (xlen == 64);
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Byte-lane steering for one access: word-crossing detection, store data/strobe
// shifting across two beats, and load extraction with sign/zero extension.
module mau_lane_align
  import mem_access_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  logic [2:0]                rw_type,
  input  logic [XLEN-1:0]           wdata,
  input  logic [XLEN-1:0]           rdata0,
  input  logic [XLEN-1:0]           rdata1,
  output logic                      split_c,
  output logic [XLEN-1:0]           wdata0_c,
  output logic [XLEN-1:0]           wdata1_c,
  output logic [XLEN/8-1:0]         wstrb0_c,
  output logic [XLEN/8-1:0]         wstrb1_c,
  output logic [XLEN-1:0]           ldata_c
);

  localparam int unsigned NB = XLEN / 8;

  logic [3:0]        size;
  logic [NB-1:0]     bmask;
  logic [XLEN-1:0]   wmask;
  logic [XLEN-1:0]   low;
  logic [2*XLEN-1:0] wide_w;
  logic [2*NB-1:0]   wide_s;
  logic              fill;

  always_comb begin
    size    = size_of(rw_type);
    split_c = (5'(off) + 5'(size)) > 5'(NB);

    bmask = '0;
    wmask = '0;
    for (int i = 0; i < NB; i++) begin
      bmask[i]        = (4'(i) < size);
      wmask[8*i +: 8] = {8{bmask[i]}};
    end

    // Store: right-justified data slides up by the byte offset over a two-word window.
    wide_w = {{XLEN{1'b0}}, wdata & wmask} << {off, 3'b000};
    wide_s = {{NB{1'b0}}, bmask} << off;

    // Load: the two beats form one little-endian window, shifted down to byte 0.
    low  = XLEN'({rdata1, rdata0} >> {off, 3'b000});
    fill = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (4'(i + 1) == size) fill = low[8*i+7] & ~rw_type[2];
    end
    ldata_c = '0;
    for (int i = 0; i < NB; i++) begin
      ldata_c[8*i +: 8] = bmask[i] ? low[8*i +: 8] : {8{fill}};
    end
  end

  assign wdata0_c = wide_w[XLEN-1:0];
  assign wdata1_c = wide_w[2*XLEN-1:XLEN];
  assign wstrb0_c = wide_s[NB-1:0];
  assign wstrb1_c = wide_s[2*NB-1:NB];

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: one CPU access per handshake, one or two
// req/ack bus beats with timeout, registered one-cycle response.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned ALLOW_MISALIGNED = 1,
  parameter int unsigned ACK_TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_type,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        type_q, type_d;
  logic [OW-1:0]     off_q, off_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata0_q, rdata0_d;
  logic              split_q, split_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [NB-1:0]     mem_wstrb_q, mem_wstrb_d;

  logic              idle;
  logic [OW-1:0]     al_off;
  logic [2:0]        al_type;
  logic [XLEN-1:0]   al_wdata, al_rd0, al_rd1;
  logic              split_c;
  logic [XLEN-1:0]   wdata0_c, wdata1_c, ldata_c;
  logic [NB-1:0]     wstrb0_c, wstrb1_c;

  assign idle = (state_q == ST_IDLE);

  // In IDLE the aligner looks at the incoming request so beat 0 can be registered on the handshake.
  assign al_off   = idle ? req_addr[OW-1:0] : off_q;
  assign al_type  = idle ? req_type : type_q;
  assign al_wdata = idle ? req_wdata : wdata_q;
  assign al_rd0   = (state_q == ST_BEAT0) ? mem_rdata : rdata0_q;
  assign al_rd1   = (state_q == ST_BEAT1) ? mem_rdata : '0;

  mau_lane_align #(.XLEN(XLEN)) u_align (
    .off      (al_off),
    .rw_type  (al_type),
    .wdata    (al_wdata),
    .rdata0   (al_rd0),
    .rdata1   (al_rd1),
    .split_c  (split_c),
    .wdata0_c (wdata0_c),
    .wdata1_c (wdata1_c),
    .wstrb0_c (wstrb0_c),
    .wstrb1_c (wstrb1_c),
    .ldata_c  (ldata_c)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    type_d      = type_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    split_d     = split_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          type_d  = req_type;
          off_d   = req_addr[OW-1:0];
          wdata_d = req_wdata;
          split_d = split_c;
          if (!type_legal(req_type, XLEN) || (ALLOW_MISALIGNED == 0 && split_c)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = ST_BEAT0;
            cnt_d       = '0;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[XLEN-1:OW], {OW{1'b0}}};
            mem_wdata_d = wdata0_c;
            mem_wstrb_d = req_we ? wstrb0_c : '0;
          end
        end
      end

      ST_BEAT0, ST_BEAT1: begin
        if (mem_ack) begin
          if (state_q == ST_BEAT0) rdata0_d = mem_rdata;
          if (state_q == ST_BEAT0 && split_q) begin
            state_d     = ST_BEAT1;
            cnt_d       = '0;
            mem_addr_d  = mem_addr_q + XLEN'(NB);
            mem_wdata_d = wdata1_c;
            mem_wstrb_d = we_q ? wstrb1_c : '0;
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = we_q ? '0 : ldata_c;
            mem_we_d    = 1'b0;
            mem_wstrb_d = '0;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Limit reached without ack: abandon the beat and report.
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_wstrb_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      type_q      <= 3'b000;
      off_q       <= '0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      split_q     <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      type_q      <= type_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      rdata0_q    <= rdata0_d;
      split_q     <= split_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign req_ready = idle;
  assign stall     = ~idle;
  assign mem_req   = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;

endmodule
